// File: rtl/fetch_controller_if.sv
// Front-end bus between the fetch controller, instruction memory and decode.
interface fetch_controller_if;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        busy;

    // Fetch controller side
    modport master (
        input  halt, redirect_valid, redirect_pc, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, busy
    );

    // Core / memory side
    modport slave (
        output halt, redirect_valid, redirect_pc, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, busy
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues word fetches to a 1-cycle-latency
// instruction memory, buffers responses in a 2-entry FIFO toward decode,
// and handles halt, redirect and reset.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    fetch_controller_if.master bus
);
    localparam logic [1:0]  DEPTH   = 2'(BUF_DEPTH);
    localparam logic [31:0] BOOT_PC = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;

    state_t           state;
    logic [31:0]      pc_q;        // next fetch address
    logic [31:0]      ipc_q;       // PC of the request in flight
    logic             inflight_q;  // a response arrives this cycle
    logic [1:0]       occ_q;
    logic [1:0][31:0] ins_q;       // entry 0 is the head
    logic [1:0][31:0] epc_q;

    logic       redir, deq, enq, issue, valid;
    logic [1:0] occ_after;

    // Issue / flush decisions for the current cycle
    always_comb begin
        redir     = bus.redirect_valid && (state != BOOT);
        valid     = (occ_q != 2'd0);
        deq       = valid && bus.if_ready;
        // a redirect kills the response arriving now
        enq       = inflight_q && !redir;
        occ_after = occ_q - {1'b0, deq};
        // the in-flight response already owns a slot, so count it
        issue     = (state == FETCH) && !bus.halt && !redir &&
                    ((occ_after + {1'b0, inflight_q}) < DEPTH);
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = valid;
    assign bus.if_instr  = valid ? ins_q[0] : 32'h0;
    assign bus.if_pc     = valid ? epc_q[0] : 32'h0;
    assign bus.busy      = inflight_q || valid;

    // Control FSM; a redirect outranks halt so the new stream stays in FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= bus.halt ? HALTED : FETCH;
                FETCH:   if (bus.halt && !redir) state <= HALTED;
                HALTED:  if (!bus.halt) state <= FETCH;
                default: state <= BOOT;
            endcase
        end
    end

    // Fetch PC and in-flight tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= BOOT_PC;
            ipc_q      <= 32'h0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (redir) begin
                pc_q <= bus.redirect_pc & 32'hFFFF_FFFC;
            end else if (issue) begin
                pc_q  <= pc_q + 32'd4;
                ipc_q <= pc_q;
            end
        end
    end

    // Two-entry response FIFO toward decode
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
            ins_q <= '0;
            epc_q <= '0;
        end else if (redir) begin
            occ_q <= 2'd0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    ins_q[occ_q[0]] <= bus.imem_rdata;
                    epc_q[occ_q[0]] <= ipc_q;
                    occ_q           <= occ_q + 2'd1;
                end
                2'b01: begin
                    ins_q[0] <= ins_q[1];
                    epc_q[0] <= epc_q[1];
                    occ_q    <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ins_q[0] <= bus.imem_rdata;
                        epc_q[0] <= ipc_q;
                    end else begin
                        ins_q[0] <= ins_q[1];
                        epc_q[0] <= epc_q[1];
                        ins_q[1] <= bus.imem_rdata;
                        epc_q[1] <= ipc_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller. Memory returns ~addr for each word.
module tb_fetch_controller;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fetch_controller_if b0();
    fetch_controller_if b1();

    fetch_controller dut0 (.clk(clk), .rst(rst), .bus(b0));
    fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    // 1-cycle-latency instruction memories
    always @(posedge clk) if (b0.imem_req) b0.imem_rdata <= ~b0.imem_addr;
    always @(posedge clk) if (b1.imem_req) b1.imem_rdata <= ~b1.imem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench inside the BOOT cycle (cycle 0)
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        b0.halt = 1'b0; b0.redirect_valid = 1'b0; b0.redirect_pc = 32'h0; b0.if_ready = 1'b1;
        b1.halt = 1'b0; b1.redirect_valid = 1'b0; b1.redirect_pc = 32'h0; b1.if_ready = 1'b1;

        // ---- reset state and in-order streaming ----
        tick(); tick(); #1;
        chk("rst_req", b0.imem_req, 0);
        chk("rst_valid", b0.if_valid, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_instr", b0.if_instr, 0);
        chk("rst_pc", b0.if_pc, 0);
        rst = 1'b0; #1;
        chk("boot_req", b0.imem_req, 0);
        chk("boot_req_b1", b1.imem_req, 0);
        tick(); #1;                                   // c1
        chk("c1_req", b0.imem_req, 1);
        chk("c1_addr", b0.imem_addr, 32'h0);
        chk("c1_valid", b0.if_valid, 0);
        chk("c1_addr_b1", b1.imem_addr, 32'hFFFF_FFF8);
        tick(); #1;                                   // c2
        chk("c2_addr", b0.imem_addr, 32'h4);
        chk("c2_busy", b0.busy, 1);
        chk("c2_valid", b0.if_valid, 0);
        tick(); #1;                                   // c3
        chk("c3_valid", b0.if_valid, 1);
        chk("c3_pc", b0.if_pc, 32'h0);
        chk("c3_instr", b0.if_instr, 32'hFFFF_FFFF);
        chk("c3_addr", b0.imem_addr, 32'h8);
        chk("c3_pc_b1", b1.if_pc, 32'hFFFF_FFF8);
        tick(); #1;                                   // c4
        chk("c4_pc", b0.if_pc, 32'h4);
        chk("c4_pc_b1", b1.if_pc, 32'hFFFF_FFFC);
        tick(); #1;                                   // c5
        chk("c5_pc", b0.if_pc, 32'h8);
        chk("c5_instr", b0.if_instr, 32'hFFFF_FFF7);
        chk("c5_valid_b1", b1.if_valid, 1);
        chk("c5_pc_b1", b1.if_pc, 32'h0);
        chk("c5_instr_b1", b1.if_instr, 32'hFFFF_FFFF);

        // ---- backpressure: decode stalls for 5 cycles ----
        b0.if_ready = 1'b0;
        do_reset();
        tick(); #1; chk("bp_c1_addr", b0.imem_addr, 32'h0);
        tick(); #1; chk("bp_c2_addr", b0.imem_addr, 32'h4);
        tick(); #1;
        chk("bp_c3_req", b0.imem_req, 0);
        chk("bp_c3_pc", b0.if_pc, 32'h0);
        tick(); #1;
        chk("bp_c4_req", b0.imem_req, 0);
        chk("bp_c4_pc", b0.if_pc, 32'h0);
        chk("bp_c4_busy", b0.busy, 1);
        tick(); #1;
        chk("bp_c5_req", b0.imem_req, 0);
        chk("bp_c5_instr", b0.if_instr, 32'hFFFF_FFFF);
        tick(); b0.if_ready = 1'b1; #1;
        chk("bp_c6_req", b0.imem_req, 1);
        chk("bp_c6_addr", b0.imem_addr, 32'h8);
        chk("bp_c6_pc", b0.if_pc, 32'h0);
        tick(); #1;
        chk("bp_c7_pc", b0.if_pc, 32'h4);
        chk("bp_c7_addr", b0.imem_addr, 32'hC);
        tick(); #1;
        chk("bp_c8_pc", b0.if_pc, 32'h8);
        chk("bp_c8_valid", b0.if_valid, 1);

        // ---- redirect ignored in BOOT, then redirect with work outstanding ----
        b0.if_ready = 1'b0;
        do_reset();
        b0.redirect_valid = 1'b1; b0.redirect_pc = 32'h200; #1;
        tick(); b0.redirect_valid = 1'b0; #1;
        chk("rb_c1_req", b0.imem_req, 1);
        chk("rb_c1_addr", b0.imem_addr, 32'h0);
        tick(); #1;
        tick(); #1;                                   // c3: 1 buffered, 1 in flight
        chk("rd_c3_valid", b0.if_valid, 1);
        b0.redirect_valid = 1'b1; b0.redirect_pc = 32'h0000_0103; #1;
        chk("rd_c3_req", b0.imem_req, 0);
        tick(); b0.redirect_valid = 1'b0; b0.if_ready = 1'b1; #1;
        chk("rd_c4_valid", b0.if_valid, 0);
        chk("rd_c4_busy", b0.busy, 0);
        chk("rd_c4_req", b0.imem_req, 1);
        chk("rd_c4_addr", b0.imem_addr, 32'h100);
        tick(); #1;
        chk("rd_c5_valid", b0.if_valid, 0);
        chk("rd_c5_addr", b0.imem_addr, 32'h104);
        tick(); #1;
        chk("rd_c6_valid", b0.if_valid, 1);
        chk("rd_c6_pc", b0.if_pc, 32'h100);
        chk("rd_c6_instr", b0.if_instr, 32'hFFFF_FEFF);
        tick(); #1;
        chk("rd_c7_pc", b0.if_pc, 32'h104);

        // ---- halt for 4 cycles, then redirect+halt priority ----
        do_reset();
        tick(); #1;
        tick(); #1;
        tick(); b0.halt = 1'b1; #1;                   // c3
        chk("h_c3_req", b0.imem_req, 0);
        chk("h_c3_pc", b0.if_pc, 32'h0);
        tick(); #1;
        chk("h_c4_req", b0.imem_req, 0);
        chk("h_c4_pc", b0.if_pc, 32'h4);
        chk("h_c4_busy", b0.busy, 1);
        tick(); #1;
        chk("h_c5_valid", b0.if_valid, 0);
        chk("h_c5_busy", b0.busy, 0);
        tick(); #1;
        chk("h_c6_req", b0.imem_req, 0);
        tick(); b0.halt = 1'b0; #1;
        chk("h_c7_req", b0.imem_req, 0);
        tick(); #1;
        chk("h_c8_req", b0.imem_req, 1);
        chk("h_c8_addr", b0.imem_addr, 32'h8);
        tick(); #1;
        chk("h_c9_addr", b0.imem_addr, 32'hC);
        tick(); #1;
        chk("h_c10_pc", b0.if_pc, 32'h8);
        chk("h_c10_addr", b0.imem_addr, 32'h10);
        b0.redirect_valid = 1'b1; b0.redirect_pc = 32'h40; b0.halt = 1'b1; #1;
        chk("rh_req", b0.imem_req, 0);
        tick(); b0.redirect_valid = 1'b0; b0.halt = 1'b0; #1;
        chk("rh_valid", b0.if_valid, 0);
        chk("rh_req_next", b0.imem_req, 1);
        chk("rh_addr_next", b0.imem_addr, 32'h40);
        tick(); #1;
        tick(); #1;
        chk("rh_pc", b0.if_pc, 32'h40);

        // ---- reset mid-operation ----
        b0.if_ready = 1'b0;
        do_reset();
        tick(); #1;
        tick(); #1;
        tick(); #1;                                   // c3: 1 buffered, 1 in flight
        chk("mr_c3_busy", b0.busy, 1);
        b0.if_ready = 1'b1;
        do_reset();
        chk("mr_valid", b0.if_valid, 0);
        chk("mr_busy", b0.busy, 0);
        chk("mr_req", b0.imem_req, 0);
        tick(); #1;
        chk("mr_c1_addr", b0.imem_addr, 32'h0);
        tick(); #1;
        chk("mr_c2_valid", b0.if_valid, 0);
        tick(); #1;
        chk("mr_c3_pc", b0.if_pc, 32'h0);
        chk("mr_c3_instr", b0.if_instr, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
